// File: rtl/cpu_bus_master.sv
// ---------------------------------------------------------------------------
// cpu_bus_master
//
// Purpose:
//   CPU-side master for "bus 1" (A1/D1/C1) between a CPU and its cache.
//   A single request from the CPU is turned into a two-cycle command phase
//   (tag+set, then offset), a wait for the cache's C1_RESPONSE, an optional
//   second data beat for 32-bit reads, and a one-cycle completion pulse.
//   Only one transaction is in flight at a time; there is no queuing.
//
// Ports:
//   CLK         in   clock, all state changes on the rising edge
//   RESET       in   synchronous, active-high reset
//   req_valid   in   CPU presents a request
//   req_ready   out  high in IDLE: a request is accepted at this edge
//   req_cmd     in   C1 command code to issue
//   req_addr    in   byte address {tag+set, offset}
//   req_wdata   in   32-bit write data
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  read data, valid while resp_valid is high
//   timeout_err out  one-cycle watchdog pulse (only with CPU_BUS_TIMEOUT_EN)
//   A1, D1, C1  io   bus 1, driven through tri-state enables
//
// Configuration:
//   CPU_BUS_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT_CYCLES
//                       edges and a missing response is reported on
//                       timeout_err instead of resp_valid.
// ---------------------------------------------------------------------------
module cpu_bus_master #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [CTR1_BUS_SIZE-1:0]                    req_cmd,
    input  logic [ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr,
    input  logic [31:0]                                 req_wdata,
    output logic                                        resp_valid,
    output logic [31:0]                                 resp_rdata,
`ifdef CPU_BUS_TIMEOUT_EN
    output logic                                        timeout_err,
`endif
    inout  wire  [ADDR1_BUS_SIZE-1:0]                   A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]                   D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]                    C1
);

    localparam int ADDR_W = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

    // Bus-1 command codes. C1_RESPONSE shares the WRITE32 code; the two
    // never collide because they travel in opposite directions.
    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = CTR1_BUS_SIZE'(4);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = CTR1_BUS_SIZE'(7);

    // The offset must fit in A1 for the SEND2 beat, and each D1 beat
    // carries a full 16-bit half-word.
    if (CACHE_OFFSET_SIZE > ADDR1_BUS_SIZE || DATA1_BUS_SIZE < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cpu_bus_master: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        SEND2,
        WAIT,
        RECV2,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [CTR1_BUS_SIZE-1:0] cmd_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [31:0]              wdata_q;
    logic [31:0]              rdata_q;

    logic                      a1_oe;
    logic [ADDR1_BUS_SIZE-1:0] a1_out;
    logic                      d1_oe;
    logic [DATA1_BUS_SIZE-1:0] d1_out;
    logic                      c1_oe;
    logic [CTR1_BUS_SIZE-1:0]  c1_out;

    logic is_write;
    logic accept;
    logic response_seen;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  timeout_hit;
`endif

    assign is_write      = (cmd_q == C1_WRITE8) || (cmd_q == C1_WRITE16) || (cmd_q == C1_WRITE32);
    assign accept        = (state == IDLE) && req_valid && (req_cmd != C1_NOP);
    assign response_seen = (C1 == C1_RESPONSE);

    assign A1 = a1_oe ? a1_out : {ADDR1_BUS_SIZE{1'bz}};
    assign D1 = d1_oe ? d1_out : {DATA1_BUS_SIZE{1'bz}};
    assign C1 = c1_oe ? c1_out : {CTR1_BUS_SIZE{1'bz}};

    assign resp_rdata = rdata_q;

    // State register. Reset wins over everything, including a request
    // presented on the same edge, and silently drops any transaction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and bus-drive decode. The bus is only driven in IDLE and
    // during the two command beats; from WAIT until the next IDLE all three
    // lines are left to the cache, so C1 goes back to NOP only once the
    // block is idle again.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        a1_oe      = 1'b0;
        a1_out     = '0;
        d1_oe      = 1'b0;
        d1_out     = '0;
        c1_oe      = 1'b0;
        c1_out     = C1_NOP;
`ifdef CPU_BUS_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                c1_oe     = 1'b1;
                if (accept) begin
                    next_state = SEND1;
                end
            end
            SEND1: begin
                c1_oe  = 1'b1;
                c1_out = cmd_q;
                a1_oe  = 1'b1;
                a1_out = addr_q[ADDR_W-1:CACHE_OFFSET_SIZE];
                if (is_write) begin
                    d1_oe  = 1'b1;
                    d1_out = DATA1_BUS_SIZE'(wdata_q[15:0]);
                end
                next_state = SEND2;
            end
            SEND2: begin
                c1_oe  = 1'b1;
                c1_out = cmd_q;
                a1_oe  = 1'b1;
                a1_out = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
                if (cmd_q == C1_WRITE32) begin
                    d1_oe  = 1'b1;
                    d1_out = DATA1_BUS_SIZE'(wdata_q[31:16]);
                end
                next_state = WAIT;
            end
            WAIT: begin
                if (response_seen) begin
                    next_state = (cmd_q == C1_READ32) ? RECV2 : RESP;
                end
`ifdef CPU_BUS_TIMEOUT_EN
                else if (wait_count == WAIT_LIMIT) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            RECV2: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latches and read-data assembly. rdata is cleared on
    // acceptance so writes and invalidates complete with zero, and D1 is
    // only ever captured on the response edge or in RECV2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q   <= C1_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= req_cmd;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (response_seen) begin
                        if (cmd_q == C1_READ8) begin
                            rdata_q <= {24'd0, D1[7:0]};
                        end else if (cmd_q == C1_READ16) begin
                            rdata_q <= {16'd0, D1[15:0]};
                        end else if (cmd_q == C1_READ32) begin
                            rdata_q[15:0] <= D1[15:0];
                        end
                    end
                end
                RECV2: begin
                    rdata_q[31:16] <= D1[15:0];
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CPU_BUS_TIMEOUT_EN
    // Watchdog: counts WAIT edges that saw no response; it sits at zero
    // outside WAIT so every wait starts from a fresh count. timeout_err is
    // high for the single IDLE cycle that follows the abort.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state == WAIT && next_state == WAIT) begin
                wait_count <= wait_count + 1'b1;
            end else begin
                wait_count <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_master
//
// Self-checking bench for cpu_bus_master. The bench plays the cache side of
// bus 1: whenever the master should have released a line, the bench drives
// a known pattern on it and expects to read exactly that pattern back, so a
// master that keeps driving shows up as a wrong value. Expected read data
// and the cycle on which resp_valid must appear are derived from the
// transaction description (command, wait count, response words).
// With CPU_BUS_TIMEOUT_EN defined the watchdog path is exercised as well.
// ---------------------------------------------------------------------------
module tb_cpu_bus_master;

    localparam logic [2:0] C1_NOP             = 3'd0;
    localparam logic [2:0] C1_READ8           = 3'd1;
    localparam logic [2:0] C1_READ16          = 3'd2;
    localparam logic [2:0] C1_READ32          = 3'd3;
    localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8          = 3'd5;
    localparam logic [2:0] C1_WRITE16         = 3'd6;
    localparam logic [2:0] C1_WRITE32         = 3'd7;
    localparam logic [2:0] C1_RESPONSE        = 3'd7;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    wire         req_ready;
    wire         resp_valid;
    wire  [31:0] resp_rdata;
`ifdef CPU_BUS_TIMEOUT_EN
    wire         timeout_err;
`endif
    wire  [14:0] A1;
    wire  [15:0] D1;
    wire  [2:0]  C1;

    logic        tb_a1_oe;
    logic [14:0] tb_a1;
    logic        tb_d1_oe;
    logic [15:0] tb_d1;
    logic        tb_c1_oe;
    logic [2:0]  tb_c1;

    int tests_run;
    int tests_failed;

    assign A1 = tb_a1_oe ? tb_a1 : 15'bz;
    assign D1 = tb_d1_oe ? tb_d1 : 16'bz;
    assign C1 = tb_c1_oe ? tb_c1 : 3'bz;

    cpu_bus_master #(
        .ADDR1_BUS_SIZE    (15),
        .DATA1_BUS_SIZE    (16),
        .CTR1_BUS_SIZE     (3),
        .CACHE_OFFSET_SIZE (4),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
`ifdef CPU_BUS_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .A1         (A1),
        .D1         (D1),
        .C1         (C1)
    );

    // 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Cache-side drive of bus 1; a released line gets a random pattern
    task automatic driveBus(input bit a_oe, input bit d_oe, input bit c_oe,
                            input logic [15:0] d_val, input logic [2:0] c_val);
        tb_a1_oe = a_oe;
        tb_a1    = 15'($urandom);
        tb_d1_oe = d_oe;
        tb_d1    = d_val;
        tb_c1_oe = c_oe;
        tb_c1    = c_val;
    endtask

    function automatic logic [31:0] expectedRdata(input logic [2:0] cmd, input logic [15:0] lo, input logic [15:0] hi);
        case (cmd)
            C1_READ8:  return {24'd0, lo[7:0]};
            C1_READ16: return {16'd0, lo};
            C1_READ32: return {hi, lo};
            default:   return 32'd0;
        endcase
    endfunction

    function automatic bit isWrite(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    // One full transaction, entered and left at a negedge in IDLE. With
    // hold_next the next request is presented as soon as this one is taken
    // and kept on req_valid until the master is idle again.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [15:0] lo, input logic [15:0] hi,
                                 input bit hold_next, input logic [2:0] n_cmd,
                                 input logic [18:0] n_addr, input logic [31:0] n_wdata);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        checkOutput("idle_c1", 32'(C1), 32'(C1_NOP));
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;

        @(posedge CLK); #1;
        if (hold_next) begin
            req_cmd   = n_cmd;
            req_addr  = n_addr;
            req_wdata = n_wdata;
        end else begin
            req_valid = 1'b0;
            req_cmd   = 3'($urandom);
        end
        driveBus(1'b0, !isWrite(cmd), 1'b0, 16'($urandom), C1_NOP);
        @(negedge CLK);
        checkOutput("send1_ready", 32'(req_ready), 32'd0);
        checkOutput("send1_c1", 32'(C1), 32'(cmd));
        checkOutput("send1_a1", 32'(A1), 32'(addr[18:4]));
        checkOutput("send1_d1", 32'(D1), isWrite(cmd) ? 32'(wdata[15:0]) : 32'(tb_d1));

        @(posedge CLK); #1;
        driveBus(1'b0, cmd != C1_WRITE32, 1'b0, 16'($urandom), C1_NOP);
        @(negedge CLK);
        checkOutput("send2_c1", 32'(C1), 32'(cmd));
        checkOutput("send2_a1", 32'(A1), 32'(addr[3:0]));
        checkOutput("send2_d1", 32'(D1), (cmd == C1_WRITE32) ? 32'(wdata[31:16]) : 32'(tb_d1));

        for (int w = 0; w < waits; w++) begin
            @(posedge CLK); #1;
            driveBus(1'b1, 1'b1, 1'b1, 16'($urandom), 3'($urandom_range(0, 6)));
            @(negedge CLK);
            checkOutput("wait_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("wait_a1_released", 32'(A1), 32'(tb_a1));
            checkOutput("wait_d1_released", 32'(D1), 32'(tb_d1));
            checkOutput("wait_c1_released", 32'(C1), 32'(tb_c1));
        end

        @(posedge CLK); #1;
        driveBus(1'b1, 1'b1, 1'b1, lo, C1_RESPONSE);
        @(negedge CLK);
        checkOutput("rsp_edge_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rsp_edge_d1_released", 32'(D1), 32'(lo));

        if (cmd == C1_READ32) begin
            @(posedge CLK); #1;
            driveBus(1'b1, 1'b1, 1'b1, hi, 3'($urandom_range(0, 6)));
            @(negedge CLK);
            checkOutput("recv2_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("recv2_c1_released", 32'(C1), 32'(tb_c1));
        end

        @(posedge CLK); #1;
        driveBus(1'b1, 1'b1, 1'b1, 16'($urandom), 3'($urandom_range(0, 6)));
        @(negedge CLK);
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, expectedRdata(cmd, lo, hi));
        checkOutput("resp_ready", 32'(req_ready), 32'd0);
        checkOutput("resp_c1_released", 32'(C1), 32'(tb_c1));

        @(posedge CLK); #1;
        driveBus(1'b1, 1'b1, 1'b0, 16'($urandom), C1_NOP);
        @(negedge CLK);
        checkOutput("after_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("after_ready", 32'(req_ready), 32'd1);
    endtask

`ifdef CPU_BUS_TIMEOUT_EN
    // No response ever arrives: the watchdog must abort after 8 WAIT edges
    task automatic checkTimeout();
        req_valid = 1'b1;
        req_cmd   = C1_READ16;
        req_addr  = 19'($urandom);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        driveBus(1'b0, 1'b1, 1'b0, 16'($urandom), C1_NOP);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        driveBus(1'b1, 1'b1, 1'b1, 16'($urandom), C1_NOP);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            checkOutput("to_wait_err", 32'(timeout_err), 32'd0);
            checkOutput("to_wait_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("to_wait_ready", 32'(req_ready), 32'd0);
            @(posedge CLK); #1;
        end
        driveBus(1'b1, 1'b1, 1'b0, 16'($urandom), C1_NOP);
        @(negedge CLK);
        checkOutput("to_err_pulse", 32'(timeout_err), 32'd1);
        checkOutput("to_ready", 32'(req_ready), 32'd1);
        checkOutput("to_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge CLK);
        checkOutput("to_err_cleared", 32'(timeout_err), 32'd0);
    endtask
`endif

    // Main sequence: reset, directed protocol cases, reset corner cases,
    // then a randomized run with occasional back-to-back requests.
    initial begin
        logic [2:0]  cur_cmd, nxt_cmd;
        logic [18:0] cur_addr, nxt_addr;
        logic [31:0] cur_wdata, nxt_wdata;
        bit          hold;

        tests_run    = 0;
        tests_failed = 0;
        RESET        = 1'b1;
        req_valid    = 1'b0;
        req_cmd      = C1_NOP;
        req_addr     = '0;
        req_wdata    = '0;
        driveBus(1'b1, 1'b1, 1'b0, 16'($urandom), C1_NOP);

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_held_ready", 32'(req_ready), 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        checkOutput("rst_c1", 32'(C1), 32'(C1_NOP));
        checkOutput("rst_a1_released", 32'(A1), 32'(tb_a1));
        checkOutput("rst_d1_released", 32'(D1), 32'(tb_d1));

        // NOP requests are ignored
        req_valid = 1'b1;
        req_cmd   = C1_NOP;
        repeat (2) begin
            @(negedge CLK);
            checkOutput("nop_ready", 32'(req_ready), 32'd1);
            checkOutput("nop_a1_released", 32'(A1), 32'(tb_a1));
        end
        req_valid = 1'b0;

        // Invalidate of tag+set 1, offset 2, cache answers after 5 cycles
        applyStimulus(C1_INVALIDATE_LINE, 19'h00012, 32'h0, 5, 16'hA5A5, 16'h0, 1'b0, C1_NOP, '0, '0);
        // 32-bit read assembled from two beats
        applyStimulus(C1_READ32, 19'h00123, 32'h0, 2, 16'hBEEF, 16'hDEAD, 1'b0, C1_NOP, '0, '0);
        // Same wait on a 16-bit read: one cycle shorter
        applyStimulus(C1_READ16, 19'h00123, 32'h0, 2, 16'hBEEF, 16'hDEAD, 1'b0, C1_NOP, '0, '0);
        // Byte read must zero-extend
        applyStimulus(C1_READ8, 19'h7FFFF, 32'h0, 0, 16'hFF81, 16'h0, 1'b0, C1_NOP, '0, '0);
        // 32-bit write split over both command beats
        applyStimulus(C1_WRITE32, 19'h4567A, 32'h12345678, 1, 16'hFFFF, 16'h0, 1'b0, C1_NOP, '0, '0);

        // Reset in WAIT drops the transaction
        req_valid = 1'b1;
        req_cmd   = C1_READ16;
        req_addr  = 19'h01234;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        driveBus(1'b0, 1'b1, 1'b0, 16'($urandom), C1_NOP);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        driveBus(1'b1, 1'b1, 1'b1, 16'($urandom), C1_NOP);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        driveBus(1'b1, 1'b1, 1'b0, 16'($urandom), C1_NOP);
        @(negedge CLK);
        checkOutput("rst_wait_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_wait_c1", 32'(C1), 32'(C1_NOP));
        repeat (4) begin
            @(negedge CLK);
            checkOutput("rst_wait_no_resp", 32'(resp_valid), 32'd0);
            checkOutput("rst_wait_idle", 32'(req_ready), 32'd1);
        end

        // Reset and request on the same edge: reset wins
        RESET     = 1'b1;
        req_valid = 1'b1;
        req_cmd   = C1_READ8;
        @(posedge CLK); #1;
        RESET     = 1'b0;
        req_valid = 1'b0;
        @(negedge CLK);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_req_c1", 32'(C1), 32'(C1_NOP));
        checkOutput("rst_req_a1_released", 32'(A1), 32'(tb_a1));

`ifdef CPU_BUS_TIMEOUT_EN
        checkTimeout();
`endif

        // Randomized transactions
        cur_cmd   = 3'($urandom_range(1, 7));
        cur_addr  = 19'($urandom);
        cur_wdata = $urandom;
        for (int i = 0; i < 40; i++) begin
            nxt_cmd   = 3'($urandom_range(1, 7));
            nxt_addr  = 19'($urandom);
            nxt_wdata = $urandom;
            hold      = (i < 39) && ($urandom_range(0, 2) == 0);
            applyStimulus(cur_cmd, cur_addr, cur_wdata, $urandom_range(0, 4),
                          16'($urandom), 16'($urandom), hold, nxt_cmd, nxt_addr, nxt_wdata);
            cur_cmd   = nxt_cmd;
            cur_addr  = nxt_addr;
            cur_wdata = nxt_wdata;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 Parameter ADDR1_BUS_SIZE, default 15: A1 bus width, carrying tag+set.
REQ-002 Parameter DATA1_BUS_SIZE, default 16: D1 bus width.
REQ-003 Parameter CTR1_BUS_SIZE, default 3: C1 bus width.
REQ-004 Parameter CACHE_OFFSET_SIZE, default 4: offset bits of the CPU address.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: response watchdog limit, used only under the REQ-030 macro.
REQ-006 CLK  in  1  clock; every state change SHALL occur on the rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  the CPU presents a request.
REQ-009 req_ready  out  1  the block accepts a request this cycle.
REQ-010 req_cmd  in  CTR1_BUS_SIZE  C1 command code to issue.
REQ-011 req_addr  in  ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE  byte address.
REQ-012 req_wdata  in  32  write data.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  32  read data, valid while resp_valid=1.
REQ-015 A1, D1, C1  inout  bus widths  CPU-cache bus 1; the block drives them through tri-state enables.

Function
REQ-016 The block SHALL implement states IDLE, SEND1, SEND2, WAIT, RECV2 and RESP.
REQ-017 IDLE: req_ready=1, C1 driven to C1_NOP, A1 and D1 released to z.
- Transition: req_valid=1 and req_cmd!=C1_NOP at an edge latches cmd, addr and wdata, then goes to SEND1.
- req_cmd=C1_NOP is ignored and the state stays IDLE.
REQ-018 SEND1, one cycle, req_ready=0:
- C1=cmd.
- A1=addr[top ADDR1_BUS_SIZE bits].
- D1=wdata[15:0] for C1_WRITE8/16/32; otherwise D1 released to z.
REQ-019 SEND2, one cycle:
- C1=cmd.
- A1=addr[CACHE_OFFSET_SIZE-1:0], zero-extended.
- D1=wdata[31:16] for C1_WRITE32 only; otherwise D1 released to z.
REQ-020 WAIT: A1, D1 and C1 are all released to z. C1 is sampled every edge. The first edge that sees C1==C1_RESPONSE ends the wait:
- READ8: capture D1[7:0] into rdata, zero-extended.
- READ16: capture D1 into rdata[15:0].
- READ32: capture D1 into rdata[15:0], then go to RECV2.
- All other commands: go to RESP.
REQ-021 RECV2: capture D1 into rdata[31:16] at the next edge, then go to RESP.
REQ-022 RESP, one cycle: resp_valid=1, with resp_rdata held stable. Writes and C1_INVALIDATE_LINE return rdata=0. The block then returns to IDLE, and C1 is driven to C1_NOP no earlier than that IDLE cycle.
REQ-023 Latency, acceptance edge to resp_valid: 3 cycles plus the cache's wait cycles, plus 1 extra cycle for READ32.
REQ-024 While not in IDLE, req_valid SHALL be ignored; there is no queuing.
REQ-025 A C1 value other than C1_RESPONSE during WAIT SHALL NOT end the wait.
REQ-026 Outside WAIT and RECV2, D1 SHALL never be sampled into rdata.

Reset
REQ-027 RESET=1 at an edge SHALL force IDLE in any state. The in-flight request is dropped, with no resp_valid.
REQ-028 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, C1=C1_NOP, A1=z, D1=z, internal latches cleared.
REQ-029 If RESET and req_valid are both high on the same edge, RESET SHALL win and the request is not accepted.

Configuration
REQ-030 Macro CPU_BUS_TIMEOUT_EN.
- Defined:
  - Output port timeout_err (1 bit, reset 0) exists.
  - A WAIT cycle counter starts at 0 on entry to WAIT.
  - After TIMEOUT_CYCLES edges in WAIT with no C1_RESPONSE, the block goes to IDLE, pulses timeout_err for one cycle and does not assert resp_valid.
- Undefined: the port and counter are absent, and WAIT has no limit.

Verification
REQ-031 C1_INVALIDATE_LINE with addr=(1<<4)|2: SEND1 drives A1=1, SEND2 drives A1=2, then the bus goes z. The cache responds after 5 cycles, and resp_valid pulses once with rdata=0.
REQ-032 C1_READ32 with addr=0x00123 and cache D1 0xBEEF then 0xDEAD: resp_rdata=0xDEADBEEF, latency 1 cycle more than C1_READ16.
REQ-033 C1_WRITE32 with wdata=0x12345678: D1=0x5678 in SEND1, D1=0x1234 in SEND2, D1=z from WAIT onward.
REQ-034 RESET asserted during WAIT: the next cycle is IDLE with C1=C1_NOP. A later C1_RESPONSE produces no resp_valid.
REQ-035 With CPU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response: timeout_err pulses after 8 WAIT edges, resp_valid stays 0, and req_ready returns to 1.
REQ-036 Back-to-back req_valid: a second request held during a busy transaction is accepted only on the first IDLE edge after RESP.
